// File: rtl/song_sequencer.sv
// Note-ROM song sequencer: fetches 32-bit note words, times each note in beats,
// inserts an optional silent gap, and drives a tone generator.
module song_sequencer #(
    parameter int ADDR_WIDTH  = 6,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 1_250_000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  play,
    input  logic                  stop,
    input  logic                  loop_enable,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [31:0]           rom_data,
    output logic [23:0]           tone_switch_period,
    output logic                  output_enable,
    output logic                  volume,
    output logic                  busy,
    output logic                  done
);

    localparam int BEAT_W = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam int GAP_LAST_INT = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(BEAT_CYCLES - 1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_LAST_INT);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        PLAY,
        GAP
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] addr_next;
    logic [23:0]           period_next;
    logic                  oe_next;
    logic                  vol_next;
    logic                  done_next;
    logic [BEAT_W-1:0]     cycle_cnt, cycle_next;
    logic [5:0]            beat_cnt, beat_next;
    logic [GAP_W-1:0]      gap_cnt, gap_next;
    logic                  note_done;
    logic                  song_end;

    // Note word fields
    logic [23:0] word_period;
    logic [5:0]  word_duration;
    logic        word_volume;
    logic        word_rest;

    assign word_period   = rom_data[23:0];
    assign word_duration = rom_data[29:24];
    assign word_volume   = rom_data[30];
    assign word_rest     = rom_data[31];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: registers are updated with <= so every flop samples the
            // pre-edge values computed by the combinational block.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every signal assigned here gets a hold/default value first,
        // otherwise paths that skip an assignment would infer a latch.
        state_next  = state;
        addr_next   = rom_addr;
        period_next = tone_switch_period;
        oe_next     = output_enable;
        vol_next    = volume;
        done_next   = 1'b0;
        cycle_next  = cycle_cnt;
        beat_next   = beat_cnt;
        gap_next    = gap_cnt;
        note_done   = 1'b0;
        song_end    = 1'b0;

        unique case (state)
            IDLE: begin
                if (play && !stop) begin
                    state_next = FETCH;
                    addr_next  = '0;
                end
            end

            FETCH: begin
                state_next = LOAD;
            end

            LOAD: begin
                if (word_duration == 6'd0) begin
                    song_end = 1'b1;
                end else begin
                    state_next  = PLAY;
                    period_next = word_period;
                    vol_next    = word_volume;
                    oe_next     = ~word_rest;
                    beat_next   = word_duration - 6'd1;
                    cycle_next  = '0;
                end
            end

            PLAY: begin
                if (cycle_cnt == BEAT_LAST) begin
                    cycle_next = '0;
                    if (beat_cnt == 6'd0) begin
                        oe_next = 1'b0;
                        if (GAP_CYCLES > 0) begin
                            state_next = GAP;
                            gap_next   = '0;
                        end else begin
                            note_done = 1'b1;
                        end
                    end else begin
                        beat_next = beat_cnt - 6'd1;
                    end
                end else begin
                    cycle_next = cycle_cnt + 1'b1;
                end
            end

            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    gap_next  = '0;
                    note_done = 1'b1;
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        if (note_done) begin
            if (rom_addr == ADDR_LAST) begin
                song_end = 1'b1;
            end else begin
                addr_next  = rom_addr + 1'b1;
                state_next = FETCH;
            end
        end

        // Looping from an empty song at address 0 would spin forever, so
        // a terminator at address 0 always ends the song.
        if (song_end) begin
            if (loop_enable && (rom_addr != '0)) begin
                addr_next  = '0;
                state_next = FETCH;
            end else begin
                state_next  = IDLE;
                done_next   = 1'b1;
                addr_next   = '0;
                period_next = '0;
                vol_next    = 1'b0;
                oe_next     = 1'b0;
            end
        end

        if (stop && (state != IDLE)) begin
            state_next  = IDLE;
            done_next   = 1'b0;
            addr_next   = '0;
            period_next = '0;
            vol_next    = 1'b0;
            oe_next     = 1'b0;
            cycle_next  = '0;
            beat_next   = '0;
            gap_next    = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr           <= '0;
            tone_switch_period <= '0;
            output_enable      <= 1'b0;
            volume             <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            cycle_cnt          <= '0;
            beat_cnt           <= '0;
            gap_cnt            <= '0;
        end else begin
            rom_addr           <= addr_next;
            tone_switch_period <= period_next;
            output_enable      <= oe_next;
            volume             <= vol_next;
            busy               <= (state_next != IDLE);
            done               <= done_next;
            cycle_cnt          <= cycle_next;
            beat_cnt           <= beat_next;
            gap_cnt            <= gap_next;
        end
    end

endmodule
